// File: rtl/phaser_tdm_sched.sv
// Per-sample scheduler that time-multiplexes one shared all-pass engine
// across TAPS cascaded phaser stages, with bypass and watchdog fallback.
module phaser_tdm_sched #(
  parameter int unsigned TAPS    = 5,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_sample,
  input  logic [DW-1:0] coef,
  input  logic          bypass,
  input  logic          clear_err,
  output logic          eng_req,
  output logic [2:0]    eng_stage,
  output logic [DW-1:0] eng_x,
  output logic [DW-1:0] eng_coef,
  input  logic          eng_ack,
  input  logic          eng_rvalid,
  input  logic [DW-1:0] eng_y,
  output logic          out_valid,
  output logic [DW-1:0] out_sample,
  output logic          busy,
  output logic          overrun,
  output logic          timeout_err
);

  localparam int unsigned SW   = 3;
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [SW-1:0]   LAST_STAGE = SW'(TAPS - 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  logic [1:0]      state_q,      state_d;
  logic [SW-1:0]   stage_q,      stage_d;
  logic [DW-1:0]   x_q,          x_d;
  logic [DW-1:0]   x_in_q,       x_in_d;
  logic [DW-1:0]   coef_q,       coef_d;
  logic [WD_W-1:0] wd_q,         wd_d;
  logic            eng_req_q,    eng_req_d;
  logic            out_valid_q,  out_valid_d;
  logic [DW-1:0]   out_sample_q, out_sample_d;
  logic            busy_q,       busy_d;
  logic            overrun_q,    overrun_d;
  logic            timeout_q,    timeout_d;
  logic            overrun_set;
  logic            timeout_set;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      stage_q      <= '0;
      x_q          <= '0;
      x_in_q       <= '0;
      coef_q       <= '0;
      wd_q         <= '0;
      eng_req_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      x_q          <= x_d;
      x_in_q       <= x_in_d;
      coef_q       <= coef_d;
      wd_q         <= wd_d;
      eng_req_q    <= eng_req_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    x_d          = x_q;
    x_in_d       = x_in_q;
    coef_d       = coef_q;
    wd_d         = wd_q;
    out_valid_d  = 1'b0;
    out_sample_d = out_sample_q;
    overrun_set  = 1'b0;
    timeout_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (bypass) begin
            out_sample_d = in_sample;
            out_valid_d  = 1'b1;
          end else begin
            x_d     = in_sample;
            x_in_d  = in_sample;
            coef_d  = coef;
            stage_d = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (eng_req_q && eng_ack) begin
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_rvalid) begin
          x_d = eng_y;
          if (stage_q == LAST_STAGE) begin
            out_sample_d = eng_y;
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
          end else begin
            stage_d = stage_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else if (wd_q == WD_LAST) begin
          // Engine stalled: fall back to the dry input sample
          timeout_set  = 1'b1;
          out_sample_d = x_in_q;
          out_valid_d  = 1'b1;
          state_d      = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (in_valid && (state_q != S_IDLE)) begin
      overrun_set = 1'b1;
    end

    // Set has priority over a coincident clear
    overrun_d = overrun_set | (overrun_q & ~clear_err);
    timeout_d = timeout_set | (timeout_q & ~clear_err);
    eng_req_d = (state_d == S_ISSUE);
    busy_d    = (state_d != S_IDLE);
  end

  assign eng_req     = eng_req_q;
  assign eng_stage   = stage_q;
  assign eng_x       = x_q;
  assign eng_coef    = coef_q;
  assign out_valid   = out_valid_q;
  assign out_sample  = out_sample_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_phaser_tdm_sched.sv
// Scoreboard bench for phaser_tdm_sched with a behavioural y = x + 1 engine
// whose ack/result delays, stalled stage and slow stage are adjustable.
module tb_phaser_tdm_sched;

  localparam int TAPS = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, bypass, clear_err;
  logic [15:0] in_sample, coef;
  logic        eng_req, eng_ack, eng_rvalid;
  logic [2:0]  eng_stage;
  logic [15:0] eng_x, eng_coef, eng_y;
  logic        out_valid, busy, overrun, timeout_err;
  logic [15:0] out_sample;

  phaser_tdm_sched dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sample(in_sample),
    .coef(coef), .bypass(bypass), .clear_err(clear_err),
    .eng_req(eng_req), .eng_stage(eng_stage), .eng_x(eng_x), .eng_coef(eng_coef),
    .eng_ack(eng_ack), .eng_rvalid(eng_rvalid), .eng_y(eng_y),
    .out_valid(out_valid), .out_sample(out_sample), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] s;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Output monitor: every out_valid must match the oldest expected result
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_sample", 32'(out_sample), 32'(mon_e.s));
        if (mon_e.cyc >= 0) chk("out_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  int req_cnt = 0;
  always @(negedge clk) if (eng_req) req_cnt++;

  // Engine model
  int          ack_dly = 0, rv_dly = 0, drop_stage = -1, slow_stage = -1;
  int          ack_cnt = 0, rcnt = 0, exp_stage = 0;
  bit          pend = 1'b0;
  logic [15:0] px, held_x, cur_coef;
  logic [2:0]  held_st;

  initial begin
    eng_ack = 1'b0; eng_rvalid = 1'b0; eng_y = '0;
    forever begin
      @(negedge clk);
      eng_ack = 1'b0;
      eng_rvalid = 1'b0;
      if (pend) begin
        if (rcnt == 0) begin
          eng_rvalid = 1'b1;
          eng_y = px + 16'd1;
          pend = 1'b0;
        end else begin
          rcnt--;
        end
      end
      if (ack_cnt > 0 && !pend) begin
        chk("req_held", 32'(eng_req), 32'd1);
        chk("req_x_hold", 32'(eng_x), 32'(held_x));
        chk("req_stage_hold", 32'(eng_stage), 32'(held_st));
      end
      if (eng_req && !pend && reset_n) begin
        if (ack_cnt == 0) begin
          held_x = eng_x;
          held_st = eng_stage;
        end
        if (ack_cnt >= ack_dly) begin
          eng_ack = 1'b1;
          ack_cnt = 0;
          chk("eng_stage", 32'(eng_stage), 32'(exp_stage));
          chk("eng_coef", 32'(eng_coef), 32'(cur_coef));
          px = eng_x;
          pend = (int'(eng_stage) != drop_stage);
          rcnt = (int'(eng_stage) == slow_stage) ? 10 : rv_dly;
          exp_stage++;
        end else begin
          ack_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] s, input logic [15:0] c, input bit byp,
                      input int lat, input logic [15:0] exp_s, input bit expect_out);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_sample = s; coef = c; bypass = byp;
    if (expect_out) begin
      if (!byp) begin
        cur_coef = c;
        exp_stage = 0;
      end
      e.s = exp_s;
      e.cyc = (lat < 0) ? -1 : cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; in_valid = 1'b0; bypass = 1'b0; clear_err = 1'b0;
    in_sample = '0; coef = '0; cur_coef = '0;
    repeat (3) @(negedge clk);
    chk("rst_eng_req", 32'(eng_req), 32'd0);
    chk("rst_eng_stage", 32'(eng_stage), 32'd0);
    chk("rst_eng_x", 32'(eng_x), 32'd0);
    chk("rst_eng_coef", 32'(eng_coef), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sample", 32'(out_sample), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait engine, nominal latency
    send(16'h0100, 16'h0800, 1'b0, 2 * TAPS + 1, 16'h0105, 1'b1);
    drain(100);
    chk("zw_stages", 32'(exp_stage), 32'(TAPS));
    chk("zw_overrun", 32'(overrun), 32'd0);

    // Stretched handshake
    ack_dly = 3; rv_dly = 2;
    send(16'h1234, 16'h0321, 1'b0, -1, 16'h1239, 1'b1);
    drain(300);
    chk("dly_stages", 32'(exp_stage), 32'(TAPS));
    chk("dly_overrun", 32'(overrun), 32'd0);
    ack_dly = 0; rv_dly = 0;

    // Overrun: second sample 4 cycles later is dropped
    send(16'h2000, 16'h0100, 1'b0, 2 * TAPS + 1, 16'h2005, 1'b1);
    repeat (2) @(negedge clk);
    send(16'h5555, 16'h0000, 1'b0, -1, 16'h0000, 1'b0);
    drain(100);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_stages", 32'(exp_stage), 32'(TAPS));
    pulse_clear();
    chk("ovr_clear", 32'(overrun), 32'd0);

    // Watchdog: stage 2 never returns, dry fallback
    drop_stage = 2;
    send(16'hF000, 16'h0400, 1'b0, 70, 16'hF000, 1'b1);
    drain(200);
    chk("to_flag", 32'(timeout_err), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_stages", 32'(exp_stage), 32'd3);
    drop_stage = -1;
    send(16'h0010, 16'h0400, 1'b0, 2 * TAPS + 1, 16'h0015, 1'b1);
    drain(100);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    pulse_clear();
    chk("to_clear", 32'(timeout_err), 32'd0);

    // Bypass
    req_cnt = 0;
    send(16'h7FFF, 16'h1111, 1'b1, 1, 16'h7FFF, 1'b1);
    drain(20);
    chk("byp_no_req", 32'(req_cnt), 32'd0);
    bypass = 1'b0;

    // Reset during stage 3 WAIT, engine answers late
    slow_stage = 3; exp_stage = 0; cur_coef = 16'h0200;
    send(16'h0A00, 16'h0200, 1'b0, -1, 16'h0000, 1'b0);
    n = 0;
    while (!(eng_stage == 3'd3 && busy && !eng_req) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_stage", 32'(eng_stage), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("arst_eng_req", 32'(eng_req), 32'd0);
    chk("arst_eng_stage", 32'(eng_stage), 32'd0);
    chk("arst_eng_x", 32'(eng_x), 32'd0);
    chk("arst_eng_coef", 32'(eng_coef), 32'd0);
    chk("arst_out_sample", 32'(out_sample), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    slow_stage = -1;
    send(16'h0300, 16'h0100, 1'b0, 2 * TAPS + 1, 16'h0305, 1'b1);
    drain(100);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
